// File: rtl/rat_io_pkg.sv
`default_nettype none
// =====================================================================
// rat_io_pkg -- shared types, default port IDs and IRQ register offsets
// Rev 1.0
// =====================================================================
package rat_io_pkg;

  typedef logic [7:0] port_id_t;
  typedef logic [7:0] byte_t;

  localparam port_id_t DEF_IN_BASE_ID  = 8'h20;
  localparam port_id_t DEF_OUT_BASE_ID = 8'h40;
  localparam port_id_t DEF_IRQ_BASE_ID = 8'hF0;

  localparam port_id_t MASK_OFS = 8'd0;
  localparam port_id_t STAT_OFS = 8'd1;
  localparam port_id_t ACK_OFS  = 8'd2;
  localparam int       IRQ_SPAN = 3;

  function automatic bit ranges_overlap(input int a, input int alen,
                                        input int b, input int blen);
    return (a < b + blen) && (b < a + alen);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rat_sync2.sv
`default_nettype none
// =====================================================================
// rat_sync2 -- WIDTH-bit two-flop synchroniser, async active-low reset
// Rev 1.0
// =====================================================================
module rat_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rat_io_hub.sv
`default_nettype none
// =====================================================================
// rat_io_hub -- RAT MCU port-bus I/O hub: synchronised inputs, output
// registers, change-detect IRQ (macro RAT_IO_IRQ_EN), half-rate MCU_CE.
// Rev 1.0
// =====================================================================
module rat_io_hub
  import rat_io_pkg::*;
#(
  parameter int       NUM_IN      = 2,
  parameter int       NUM_OUT     = 2,
  parameter port_id_t IN_BASE_ID  = DEF_IN_BASE_ID,
  parameter port_id_t OUT_BASE_ID = DEF_OUT_BASE_ID,
  parameter port_id_t IRQ_BASE_ID = DEF_IRQ_BASE_ID
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  output logic                 MCU_CE,
  input  logic [7:0]           PORT_ID,
  input  logic [7:0]           OUT_PORT,
  input  logic                 IO_STRB,
  output logic [7:0]           IN_PORT,
  output logic                 INTERRUPT,
  input  logic [8*NUM_IN-1:0]  IN_DATA,
  output logic [8*NUM_OUT-1:0] OUT_DATA
);

  if (NUM_IN < 1 || NUM_IN > 8 || NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_size
    $error("rat_io_hub: NUM_IN and NUM_OUT must be in 1..8");
  end

  if (ranges_overlap(int'(IN_BASE_ID), NUM_IN, int'(OUT_BASE_ID), NUM_OUT) ||
      ranges_overlap(int'(IN_BASE_ID), NUM_IN, int'(IRQ_BASE_ID), IRQ_SPAN) ||
      ranges_overlap(int'(OUT_BASE_ID), NUM_OUT, int'(IRQ_BASE_ID), IRQ_SPAN)) begin : g_bad_ids
    $error("rat_io_hub: port ID ranges overlap");
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) MCU_CE <= 1'b0;
    else          MCU_CE <= ~MCU_CE;
  end

  logic [8*NUM_IN-1:0] sync_data;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
    rat_sync2 #(.WIDTH(8)) u_sync (
      .clk   (CLK),
      .rst_n (RESET_N),
      .d     (IN_DATA[8*k +: 8]),
      .q     (sync_data[8*k +: 8])
    );
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OUT_DATA <= '0;
    end else if (IO_STRB) begin
      for (int k = 0; k < NUM_OUT; k++)
        if (PORT_ID == port_id_t'(OUT_BASE_ID + k)) OUT_DATA[8*k +: 8] <= OUT_PORT;
    end
  end

`ifdef RAT_IO_IRQ_EN
  localparam byte_t CHAN_MASK = byte_t'((1 << NUM_IN) - 1);

  logic [8*NUM_IN-1:0] prev_data;
  byte_t               mask;
  byte_t               pending;
  byte_t               event_vec;
  logic                wr_mask;
  logic                wr_ack;

  assign wr_mask = IO_STRB && (PORT_ID == port_id_t'(IRQ_BASE_ID + MASK_OFS));
  assign wr_ack  = IO_STRB && (PORT_ID == port_id_t'(IRQ_BASE_ID + ACK_OFS));

  always_comb begin
    event_vec = '0;
    for (int k = 0; k < NUM_IN; k++)
      event_vec[k] = (sync_data[8*k +: 8] != prev_data[8*k +: 8]);
  end

  // A new event ORs in after the acknowledge, so a coincident set wins.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_data <= '0;
      mask      <= '0;
      pending   <= '0;
      INTERRUPT <= 1'b0;
    end else begin
      prev_data <= sync_data;
      if (wr_mask) mask <= OUT_PORT & CHAN_MASK;
      pending   <= (wr_ack ? (pending & ~OUT_PORT) : pending) | event_vec;
      INTERRUPT <= |(pending & mask);
    end
  end
`else
  assign INTERRUPT = 1'b0;
`endif

  always_comb begin
    IN_PORT = 8'h00;
    for (int k = 0; k < NUM_IN; k++)
      if (PORT_ID == port_id_t'(IN_BASE_ID + k)) IN_PORT = sync_data[8*k +: 8];
    for (int k = 0; k < NUM_OUT; k++)
      if (PORT_ID == port_id_t'(OUT_BASE_ID + k)) IN_PORT = OUT_DATA[8*k +: 8];
`ifdef RAT_IO_IRQ_EN
    if (PORT_ID == port_id_t'(IRQ_BASE_ID + MASK_OFS)) IN_PORT = mask;
    if (PORT_ID == port_id_t'(IRQ_BASE_ID + STAT_OFS)) IN_PORT = pending;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_rat_io_hub.sv
`default_nettype none
// =====================================================================
// tb_rat_io_hub -- randomized self-checking bench against a history-based model
// Rev 1.0
// =====================================================================
`timescale 1ns/1ps
module tb_rat_io_hub;
  import rat_io_pkg::*;

  localparam int NUM_IN  = 2;
  localparam int NUM_OUT = 2;
  localparam int INW     = 8 * NUM_IN;
  localparam int OUTW    = 8 * NUM_OUT;
`ifdef RAT_IO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            MCU_CE;
  logic [7:0]      PORT_ID = 8'h00;
  logic [7:0]      OUT_PORT = 8'h00;
  logic            IO_STRB = 1'b0;
  logic [7:0]      IN_PORT;
  logic            INTERRUPT;
  logic [INW-1:0]  IN_DATA = '0;
  logic [OUTW-1:0] OUT_DATA;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  rat_io_hub #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .MCU_CE    (MCU_CE),
    .PORT_ID   (PORT_ID),
    .OUT_PORT  (OUT_PORT),
    .IO_STRB   (IO_STRB),
    .IN_PORT   (IN_PORT),
    .INTERRUPT (INTERRUPT),
    .IN_DATA   (IN_DATA),
    .OUT_DATA  (OUT_DATA)
  );

  // Model: hist[0] is the input sampled at the latest edge, hist[1] the one before, ...
  logic [INW-1:0] hist [3];
  byte_t          m_out [NUM_OUT];
  byte_t          m_mask;
  byte_t          m_pend;
  bit             m_irq;
  bit             m_ce;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    for (int i = 0; i < NUM_OUT; i++) m_out[i] = 8'h00;
    m_mask = 8'h00;
    m_pend = 8'h00;
    m_irq  = 1'b0;
    m_ce   = 1'b0;
  endtask

  task automatic model_edge();
    byte_t evt;
    bit    irq_n;
    evt   = 8'h00;
    for (int c = 0; c < NUM_IN; c++)
      evt[c] = (hist[1][8*c +: 8] != hist[2][8*c +: 8]);
    irq_n = IRQ_ON && ((m_pend & m_mask) != 8'h00);
    if (IRQ_ON) begin
      for (int c = 0; c < NUM_IN; c++) begin
        if (evt[c]) m_pend[c] = 1'b1;
        else if (IO_STRB && PORT_ID == 8'hF2 && OUT_PORT[c]) m_pend[c] = 1'b0;
      end
      if (IO_STRB && PORT_ID == 8'hF0) m_mask = OUT_PORT & byte_t'((1 << NUM_IN) - 1);
    end
    if (IO_STRB && PORT_ID >= 8'h40 && int'(PORT_ID) < 'h40 + NUM_OUT)
      m_out[int'(PORT_ID) - 'h40] = OUT_PORT;
    m_irq   = irq_n;
    m_ce    = !m_ce;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = IN_DATA;
  endtask

  function automatic byte_t model_read(input byte_t id);
    int idx;
    idx = int'(id);
    if (idx >= 'h20 && idx < 'h20 + NUM_IN) return hist[1][8*(idx - 'h20) +: 8];
    if (idx >= 'h40 && idx < 'h40 + NUM_OUT) return m_out[idx - 'h40];
    if (IRQ_ON && idx == 'hF0) return m_mask;
    if (IRQ_ON && idx == 'hF1) return m_pend;
    return 8'h00;
  endfunction

  function automatic logic [OUTW-1:0] model_out();
    logic [OUTW-1:0] v;
    for (int i = 0; i < NUM_OUT; i++) v[8*i +: 8] = m_out[i];
    return v;
  endfunction

  task automatic cycle(input string tag, input byte_t id, input byte_t data,
                       input logic strb, input logic [INW-1:0] din);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = strb;
    IN_DATA  = din;
    @(posedge CLK);
    model_edge();
    #1;
    check_val({tag, "_ce"},   32'(MCU_CE),    32'(m_ce));
    check_val({tag, "_irq"},  32'(INTERRUPT), 32'(m_irq));
    check_val({tag, "_out"},  32'(OUT_DATA),  32'(model_out()));
    check_val({tag, "_read"}, 32'(IN_PORT),   32'(model_read(id)));
  endtask

  task automatic probe(input string tag, input byte_t id);
    PORT_ID = id;
    #1;
    check_val({tag, "_probe"}, 32'(IN_PORT), 32'(model_read(id)));
  endtask

  task automatic do_reset(input int cycles);
    RESET_N = 1'b0;
    IO_STRB = 1'b0;
    PORT_ID = 8'hF1;
    model_reset();
    #1;
    for (int i = 0; i <= cycles; i++) begin
      check_val("rst_out",  32'(OUT_DATA),  32'h0);
      check_val("rst_irq",  32'(INTERRUPT), 32'h0);
      check_val("rst_ce",   32'(MCU_CE),    32'h0);
      check_val("rst_rdF1", 32'(IN_PORT),   32'h0);
      IN_DATA = INW'($urandom);
      @(posedge CLK);
      #1;
    end
    RESET_N = 1'b1;
  endtask

  function automatic byte_t pick_id();
    case ($urandom_range(0, 5))
      0:       return byte_t'(8'h20 + $urandom_range(0, 2));
      1:       return byte_t'(8'h40 + $urandom_range(0, 2));
      2:       return 8'hF0;
      3:       return 8'hF1;
      4:       return 8'hF2;
      default: return byte_t'($urandom);
    endcase
  endfunction

  initial begin
    logic [INW-1:0] din;
    do_reset(3);
    repeat (3) cycle("idle", 8'h20, 8'h00, 1'b0, IN_DATA);
    din = '0;
    repeat (3) cycle("settle", 8'h20, 8'h00, 1'b0, din);
    cycle("wr41", 8'h41, 8'hA5, 1'b1, din);
    probe("rd41", 8'h41);
    cycle("wr41_again", 8'h41, 8'hA5, 1'b1, din);
    cycle("wr42", 8'h42, 8'h5A, 1'b1, din);
    probe("rd40", 8'h40);
    din = INW'(16'h003C);
    repeat (3) cycle("sync", 8'h20, 8'h00, 1'b0, din);
    din = '0;
    repeat (4) cycle("settle2", 8'hF1, 8'h00, 1'b0, din);
    cycle("ack_all", 8'hF2, 8'hFF, 1'b1, din);
    cycle("mask01", 8'hF0, 8'h01, 1'b1, din);
    din = INW'(16'h0001);
    repeat (5) cycle("irq0", 8'hF1, 8'h00, 1'b0, din);
    cycle("ack0", 8'hF2, 8'h01, 1'b1, din);
    repeat (2) cycle("ack0_idle", 8'hF1, 8'h00, 1'b0, din);
    din = INW'(16'h0101);
    repeat (5) cycle("ch1_unmasked", 8'hF1, 8'h00, 1'b0, din);
    din = INW'(16'h0100);
    cycle("coll_chg", 8'hF1, 8'h00, 1'b0, din);
    cycle("coll_wait", 8'hF1, 8'h00, 1'b0, din);
    cycle("coll_ack", 8'hF2, 8'h01, 1'b1, din);
    repeat (3) cycle("coll_after", 8'hF1, 8'h00, 1'b0, din);
    cycle("mask03", 8'hF0, 8'h03, 1'b1, din);
    repeat (2) cycle("mask03_idle", 8'hF0, 8'h00, 1'b0, din);
    cycle("ack_ff", 8'hF2, 8'hFF, 1'b1, din);
    repeat (2) cycle("ack_ff_idle", 8'hF1, 8'h00, 1'b0, din);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) din = INW'($urandom);
      cycle("rand", pick_id(), byte_t'($urandom), ($urandom_range(0, 2) == 0), din);
      probe("rand", pick_id());
      if (i == 150) do_reset(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
